// File: rtl/microwave_controller.sv
`default_nettype none
// ============================================================================
//  Module      : microwave_controller
//  Description : Top-level sequencer for the mm:ss countdown timer. Loads
//                keypad digits into the timer, generates the 1-second
//                countdown pulse, drives the magnetron and the done alarm.
//  Revision    : 1.0 - initial release
// ============================================================================
module microwave_controller #(
    parameter int TICK_DIV    = 50000000,
    parameter int BEEP_CYCLES = 150000000
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic [3:0] timer_number,
    output logic       timer_loadn,
    output logic       timer_clearn,
    output logic       timer_enable,
    output logic       mag_on,
    output logic       done,
    output logic [2:0] state_out
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = $clog2(BEEP_CYCLES + 1);

    localparam logic [PW-1:0] c_TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] c_TICK_ONE  = PW'(1);
    localparam logic [BW-1:0] c_BEEP_LAST = BW'(BEEP_CYCLES - 1);
    localparam logic [BW-1:0] c_BEEP_ONE  = BW'(1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_SETTING = 3'd1;
    localparam logic [2:0] c_COOKING = 3'd2;
    localparam logic [2:0] c_PAUSED  = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [BW-1:0] beep_q, beep_d;
    logic [3:0]    timer_number_q, timer_number_d;
    logic          timer_loadn_q, timer_loadn_d;
    logic          timer_clearn_q, timer_clearn_d;
    logic          timer_enable_q, timer_enable_d;
    logic          mag_on_q, mag_on_d;
    logic          done_q, done_d;

    logic w_door_open;
    logic w_digit;
    logic w_tick_wrap;
    logic w_beep_end;

    assign w_door_open = ~door_closed;
    assign w_digit     = key_valid & (key_code <= 4'd9);
    assign w_tick_wrap = (prescaler_q == c_TICK_LAST);
    assign w_beep_end  = (beep_q == c_BEEP_LAST);

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q        <= c_IDLE;
            prescaler_q    <= '0;
            beep_q         <= '0;
            timer_number_q <= 4'd0;
            timer_loadn_q  <= 1'b1;
            timer_clearn_q <= 1'b0;
            timer_enable_q <= 1'b0;
            mag_on_q       <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            prescaler_q    <= prescaler_d;
            beep_q         <= beep_d;
            timer_number_q <= timer_number_d;
            timer_loadn_q  <= timer_loadn_d;
            timer_clearn_q <= timer_clearn_d;
            timer_enable_q <= timer_enable_d;
            mag_on_q       <= mag_on_d;
            done_q         <= done_d;
        end
    end

    // Next-state selection; door open outranks stop_clear, which outranks start, then keys
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE, c_SETTING: begin
                if (stop_clear) begin
                    state_d = c_IDLE;
                end else if ((state_q == c_SETTING) && start && door_closed && !timer_zero) begin
                    state_d = c_COOKING;
                end else if (w_digit) begin
                    state_d = c_SETTING;
                end
            end
            c_COOKING: begin
                if (w_door_open || stop_clear) begin
                    state_d = c_PAUSED;
                end else if (timer_zero && !timer_enable_q) begin
                    // zero is only trusted when no decrement is in flight
                    state_d = c_DONE;
                end
            end
            c_PAUSED: begin
                if (w_door_open) begin
                    state_d = c_PAUSED;
                end else if (stop_clear) begin
                    state_d = c_IDLE;
                end else if (start) begin
                    state_d = c_COOKING;
                end
            end
            c_DONE: begin
                if (w_door_open || stop_clear || w_beep_end) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Registered outputs and counters derived from current state and chosen transition
    always_comb begin
        prescaler_d    = prescaler_q;
        beep_d         = beep_q;
        timer_number_d = timer_number_q;
        timer_loadn_d  = 1'b1;
        timer_clearn_d = 1'b1;
        timer_enable_d = 1'b0;
        mag_on_d       = (state_d == c_COOKING);
        done_d         = (state_d == c_DONE);
        case (state_q)
            c_IDLE, c_SETTING: begin
                if (stop_clear) begin
                    timer_clearn_d = 1'b0;
                end else if (state_d == c_COOKING) begin
                    prescaler_d = '0;
                end else if (w_digit) begin
                    timer_number_d = key_code;
                    timer_loadn_d  = 1'b0;
                end
            end
            c_COOKING, c_PAUSED: begin
                if (state_d == c_IDLE) begin
                    timer_clearn_d = 1'b0;
                end else if (state_d == c_COOKING) begin
                    // a resume counts as a cooking cycle, continuing from the held value
                    if (w_tick_wrap) begin
                        prescaler_d    = '0;
                        timer_enable_d = 1'b1;
                    end else begin
                        prescaler_d = prescaler_q + c_TICK_ONE;
                    end
                end
            end
            c_DONE: begin
                if (state_d == c_IDLE) begin
                    timer_clearn_d = 1'b0;
                    beep_d         = '0;
                end else begin
                    beep_d = beep_q + c_BEEP_ONE;
                end
            end
            default: begin
                timer_clearn_d = 1'b0;
            end
        endcase
    end

    assign timer_number = timer_number_q;
    assign timer_loadn  = timer_loadn_q;
    assign timer_clearn = timer_clearn_q;
    assign timer_enable = timer_enable_q;
    assign mag_on       = mag_on_q;
    assign done         = done_q;
    assign state_out    = state_q;

endmodule
`default_nettype wire
